hls_fp17_to_fp16_chn_o_rsci: RTL and testbench
==============================================

# hls_fp17_to_fp16_chn_o_rsci

Output-channel interface for the fp17→fp16 HLS core: accepts converted fp16 results from the core datapath, buffers them in a small FIFO, and presents them on the downstream valid/ready channel. It is the producer of `chn_o_rsci_wen_comp`, the per-channel write-enable-complete signal that the core staller ANDs into `core_wen`. Downstream backpressure is absorbed by the buffer rather than stalling the core every cycle.

## Interface
- `DATA_W`, 16: width of one fp16 result word.
- `DEPTH`, 2: buffer entries; power of two, ≥2.

- `nvdla_core_clk`  in  1  clock.
- `nvdla_core_rstn`  in  1  reset; asynchronous, active-low.
- `core_wen`  in  1  core advance enable from the staller. A push happens only when this is high.
- `chn_o_rsci_oswt`  in  1  core requests a write this cycle.
- `chn_o_rsci_d`  in  DATA_W  result word from the core.
- `chn_o_rsci_wen_comp`  out  1  channel ready for the core. Goes to the staller.
- `chn_o_rsc_z`  out  DATA_W  downstream data.
- `chn_o_rsc_vz`  out  1  downstream valid.
- `chn_o_rsc_lz`  in  1  downstream ready.
- `chn_o_rsci_idle`  out  1  buffer empty and no request pending.

## Operation
- State: `count` (0..DEPTH), `wr_ptr`, `rd_ptr` (log2(DEPTH) bits each, wrap modulo DEPTH), and storage array `mem[DEPTH]`.
- Combinational outputs:
  - `wen_comp = ~oswt | (count != DEPTH)`. It depends only on registered state and `oswt`. There is no combinational path from `chn_o_rsc_lz` to `wen_comp`.
  - `push = oswt & core_wen`. The staller guarantees `core_wen` implies `wen_comp`, so `push` never occurs when full.
  - `chn_o_rsc_vz = (count != 0)`.
  - `chn_o_rsc_z = mem[rd_ptr]`.
  - `pop = vz & lz`.
  - `idle = (count == 0) & ~oswt`.
- Register updates:
  - On `push`: `mem[wr_ptr] <= d` and `wr_ptr++`.
  - On `pop`: `rd_ptr++`.
  - `count` changes by +1 on `push` only, −1 on `pop` only, and is unchanged when `push` and `pop` occur together or when neither occurs.
- Full with a simultaneous pop: `wen_comp` is 0, so there is no push in that cycle. The core sees a one-cycle stall and pushes in the next cycle. This is accepted behaviour.
- Empty with a push: the word becomes visible on `z`/`vz` the following cycle. There is no bypass.
- `oswt` high with `core_wen` low (another channel stalled): no push. `wen_comp` still reflects this channel's own readiness only.
- Data contract: entries are never overwritten while valid. `z` is stable while `vz & ~lz`. Words leave in push order.
- Reset (async assert, sync-safe deassert by the system): `count`, pointers and `vz` go to 0 and `mem` clears to 0. Consequently `wen_comp = ~oswt | 1 = 1` and `idle = ~oswt`.
- Reset mid-operation discards all buffered words; none are emitted after release.

## Timing
- Push-to-visible latency: 1 cycle. Throughput: 1 word/cycle sustained while `lz` stays high.
- `wen_comp` deasserts in the cycle after `count` reaches DEPTH and reasserts in the cycle after the first pop from full.
- All state updates happen on posedge `nvdla_core_clk`. Reset is asynchronous to the clock.

## Structure
- Shared package `hls_fp17_to_fp16_pkg`: `DATA_W` default, `DEPTH` default, fp16 word typedef.
- Sub-module `hls_chn_skid_fifo`: pointers, count, storage, full/empty. This block adds the `wen_comp`/`push`/`idle` glue so the FIFO is reusable for the `chn_a` side.

## Test plan
- Reset, then `oswt=0`, `lz=0` → `wen_comp=1`, `vz=0`, `idle=1`, `z=0`.
- Push 0x3C00 and 0x4000 with `core_wen=1` and `lz=0` → `count=2`. With `oswt=1`, `wen_comp=0`. `z=0x3C00` held stable.
- Raise `lz` → 0x3C00 then 0x4000 out on consecutive cycles. `wen_comp=1` in the cycle after the first pop.
- Streaming 100 words with `lz=1` and `oswt=core_wen=1` → one output per cycle, in order, with 1-cycle latency.
- `oswt=1`, `core_wen=0` for 3 cycles → no push, `count` unchanged, `wen_comp=1`.
- Assert reset with `count=2` → `vz=0` immediately (async). After release, no stale words appear.

Source files
------------

// File: rtl/hls_fp17_to_fp16_pkg.sv
// Shared definitions for the fp17->fp16 HLS core: default word width,
// channel buffer depth and the fp16 result word type.
package hls_fp17_to_fp16_pkg;

    localparam int FP16_W    = 16;
    localparam int CHN_DEPTH = 2;

    typedef logic [FP16_W-1:0] fp16_t;

endpackage

// File: rtl/hls_chn_skid_fifo.sv
// Small power-of-two FIFO used by the HLS channel interfaces: storage,
// wrap-around pointers, occupancy count and full/empty flags.
module hls_chn_skid_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;

    // Guarding here keeps a live entry from being overwritten even if a caller misbehaves.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop  & ~o_empty;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    // NOTE: storage is reset too, so z reads 0 after reset rather than X.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hls_fp17_to_fp16_chn_o_rsci.sv
// Output channel of the fp17->fp16 core: buffers converted words and drives
// the downstream valid/ready port; produces wen_comp for the core staller.
module hls_fp17_to_fp16_chn_o_rsci
    import hls_fp17_to_fp16_pkg::*;
#(
    parameter int DATA_W = FP16_W,
    parameter int DEPTH  = CHN_DEPTH
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              core_wen,
    input  logic              chn_o_rsci_oswt,
    input  logic [DATA_W-1:0] chn_o_rsci_d,
    output logic              chn_o_rsci_wen_comp,
    output logic [DATA_W-1:0] chn_o_rsc_z,
    output logic              chn_o_rsc_vz,
    input  logic              chn_o_rsc_lz,
    output logic              chn_o_rsci_idle
);

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;

    // wen_comp looks only at registered fullness, never at downstream ready.
    assign chn_o_rsci_wen_comp = ~chn_o_rsci_oswt | ~w_full;
    assign w_push              = chn_o_rsci_oswt & core_wen;
    assign chn_o_rsc_vz        = ~w_empty;
    assign w_pop               = chn_o_rsc_vz & chn_o_rsc_lz;
    assign chn_o_rsci_idle     = w_empty & ~chn_o_rsci_oswt;

    hls_chn_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .i_push          (w_push),
        .i_pop           (w_pop),
        .i_wdata         (chn_o_rsci_d),
        .o_rdata         (chn_o_rsc_z),
        .o_full          (w_full),
        .o_empty         (w_empty)
    );

endmodule

// File: tb/tb_hls_fp17_to_fp16_chn_o_rsci.sv
// Bench for the fp17->fp16 output channel: queue model checked every cycle
// plus directed literal expectations for reset, full, drain and streaming.
module tb_hls_fp17_to_fp16_chn_o_rsci;
    import hls_fp17_to_fp16_pkg::*;

    localparam int DEPTH = CHN_DEPTH;

    logic  clk;
    logic  rstn;
    logic  core_wen;
    logic  oswt;
    fp16_t d;
    logic  wen_comp;
    fp16_t z;
    logic  vz;
    logic  lz;
    logic  idle;

    int n_checks = 0;
    int n_fail   = 0;
    int dut_pops = 0;

    fp16_t q[$];

    hls_fp17_to_fp16_chn_o_rsci dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rstn     (rstn),
        .core_wen            (core_wen),
        .chn_o_rsci_oswt     (oswt),
        .chn_o_rsci_d        (d),
        .chn_o_rsci_wen_comp (wen_comp),
        .chn_o_rsc_z         (z),
        .chn_o_rsc_vz        (vz),
        .chn_o_rsc_lz        (lz),
        .chn_o_rsci_idle     (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a FIFO of at most DEPTH words; reset empties it.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
        end else begin
            logic push;
            logic pop;
            pop  = (q.size() != 0) && lz;
            push = oswt && core_wen;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
    end

    always @(posedge clk) begin
        if (rstn && vz && lz) dut_pops++;
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        check("vz_model", {31'd0, vz}, {31'd0, q.size() != 0});
        check("wen_comp_model", {31'd0, wen_comp}, {31'd0, !oswt || (q.size() != DEPTH)});
        check("idle_model", {31'd0, idle}, {31'd0, (q.size() == 0) && !oswt});
        if (q.size() != 0) check("z_model", {16'd0, z}, {16'd0, q[0]});
    end

    task automatic drive(input logic o, input logic cw, input logic l, input fp16_t data);
        @(posedge clk);
        #1;
        oswt     = o;
        core_wen = cw;
        lz       = l;
        d        = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rstn = 1'b0; oswt = 1'b0; core_wen = 1'b0; lz = 1'b0; d = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        check("rst_wen_comp", {31'd0, wen_comp}, 32'd1);
        check("rst_vz",       {31'd0, vz},       32'd0);
        check("rst_idle",     {31'd0, idle},     32'd1);
        check("rst_z",        {16'd0, z},        32'd0);

        // Fill to DEPTH with the sink stalled.
        drive(1, 1, 0, 16'h3C00);
        drive(1, 1, 0, 16'h4000);
        drive(1, 0, 0, 16'h0000);
        #1;
        check("full_wen_comp", {31'd0, wen_comp}, 32'd0);
        check("full_vz",       {31'd0, vz},       32'd1);
        check("full_z",        {16'd0, z},        32'h3C00);
        repeat (3) drive(1, 0, 0, 16'h0000);
        #1 check("full_z_stable", {16'd0, z}, 32'h3C00);

        // Drain.
        drive(1, 0, 1, 16'h0000);
        #1 check("pre_pop_wen_comp", {31'd0, wen_comp}, 32'd0);
        drive(1, 0, 1, 16'h0000);
        #1;
        check("pop1_z",        {16'd0, z},        32'h4000);
        check("pop1_wen_comp", {31'd0, wen_comp}, 32'd1);
        drive(0, 0, 1, 16'h0000);
        #1;
        check("drained_vz",   {31'd0, vz},   32'd0);
        check("drained_idle", {31'd0, idle}, 32'd1);

        // Streaming at one word per cycle.
        base = dut_pops;
        for (int i = 0; i < 100; i++) begin
            drive(1, 1, 1, fp16_t'(16'h3C00 + i));
            if (i == 0) #1 check("stream_no_bypass", {31'd0, vz}, 32'd0);
            if (i == 1) #1 check("stream_latency_z", {16'd0, z}, 32'h3C00);
        end
        repeat (3) drive(0, 0, 1, 16'h0000);
        check("stream_count", dut_pops - base, 32'd100);

        // oswt without core_wen: no push.
        drive(1, 1, 0, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 16'hFFFF);
            #1;
            check("stall_wen_comp", {31'd0, wen_comp}, 32'd1);
            check("stall_z",        {16'd0, z},        32'h1234);
        end
        drive(1, 1, 0, 16'h5678);
        drive(0, 0, 0, 16'h0000);
        #1 check("two_held_z", {16'd0, z}, 32'h1234);

        // Asynchronous reset with two words buffered.
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("async_rst_vz",       {31'd0, vz},       32'd0);
        check("async_rst_wen_comp", {31'd0, wen_comp}, 32'd1);
        repeat (2) @(posedge clk);
        base = dut_pops;
        drive(0, 0, 1, 16'h0000);
        rstn = 1'b1;
        #1 check("post_rst_z", {16'd0, z}, 32'd0);
        repeat (3) drive(0, 0, 1, 16'h0000);
        #1;
        check("post_rst_vz",   {31'd0, vz}, 32'd0);
        check("post_rst_pops", dut_pops - base, 32'd0);

        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
